// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types and constants for the instruction prefetch path.
package cv32e40p_pkg;
  typedef enum logic {IDLE, BRANCH_WAIT} fetch_fsm_e;
  localparam int FETCH_WORD_BYTES = 4;
endpackage

// File: rtl/cv32e40p_fetch_fifo_filler.sv
// cv32e40p_fetch_fifo_filler: issues prefetch requests, tracks outstanding fetches and drops stale responses.
// Define CV32E40P_FETCH_ERR_STOP_EN to stop fetching after a bus error response until the next branch.
module cv32e40p_fetch_fifo_filler
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) + 1 : 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_enable_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_addr_i,
  output logic             trans_valid_o,
  input  logic             trans_ready_i,
  output logic [31:0]      trans_addr_o,
  input  logic             resp_valid_i,
  input  logic [31:0]      resp_rdata_i,
  input  logic             resp_err_i,
  input  logic [CNT_W-1:0] fifo_cnt_i,
  output logic             fifo_push_o,
  output logic [31:0]      fifo_wdata_o,
  output logic             fifo_flush_o,
  output logic             busy_o
);
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);
  localparam logic [31:0] STEP = 32'(FETCH_WORD_BYTES);
  fetch_fsm_e state_q, state_n;
  logic [31:0] addr_q, addr_n, stale_addr_q, target;
  logic [CNT_W-1:0] outstanding_q, outstanding_n, flush_cnt_q, flush_cnt_n;
  logic [CNT_W:0] live;
  logic pending_q, grant, stale_grant, err_stop, issue_ok;
`ifdef CV32E40P_FETCH_ERR_STOP_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else if (branch_i) err_q <= 1'b0;
    else if (fifo_push_o && resp_err_i) err_q <= 1'b1;
  end
  assign err_stop = err_q & ~branch_i;
`else
  assign err_stop = resp_err_i & 1'b0;
`endif
  // A grant is stale when it completes a request presented before the latest branch.
  always_comb begin
    target = branch_addr_i & ~(STEP - 32'd1);
    live = {1'b0, outstanding_q - flush_cnt_q} + {1'b0, fifo_cnt_i};
    issue_ok = fetch_enable_i & ~err_stop & ({1'b0, outstanding_q} < DEPTH_X) & (live < DEPTH_X);
    trans_valid_o = pending_q | ((state_q == IDLE) & issue_ok);
    trans_addr_o = (state_q == BRANCH_WAIT) ? stale_addr_q : (branch_i & ~pending_q) ? target : addr_q;
    grant = trans_valid_o & trans_ready_i;
    stale_grant = grant & ((state_q == BRANCH_WAIT) | (branch_i & pending_q));
    outstanding_n = outstanding_q + CNT_W'(grant) - CNT_W'(resp_valid_i);
    flush_cnt_n = branch_i ? outstanding_n - CNT_W'(grant & ~stale_grant)
                           : flush_cnt_q - CNT_W'(resp_valid_i && flush_cnt_q != '0) + CNT_W'(stale_grant);
    addr_n = (grant & ~stale_grant) ? trans_addr_o + STEP : branch_i ? target : addr_q;
    state_n = (state_q == IDLE) ? ((branch_i & pending_q & ~trans_ready_i) ? BRANCH_WAIT : IDLE)
                                : (grant ? IDLE : BRANCH_WAIT);
    fifo_push_o = resp_valid_i & (flush_cnt_q == '0) & ~branch_i;
  end
  assign fifo_wdata_o = resp_rdata_i;
  assign fifo_flush_o = branch_i;
  assign busy_o = outstanding_q != '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q <= '0;
      stale_addr_q <= '0;
      outstanding_q <= '0;
      flush_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q <= addr_n;
      outstanding_q <= outstanding_n;
      flush_cnt_q <= flush_cnt_n;
      pending_q <= trans_valid_o & ~trans_ready_i;
      if (state_q == IDLE) stale_addr_q <= addr_q;
    end
  end
endmodule

// File: tb/tb_cv32e40p_fetch_fifo_filler.sv
// tb_cv32e40p_fetch_fifo_filler: scenario tasks plus a push scoreboard fed by an address-epoch model.
module tb_cv32e40p_fetch_fifo_filler;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  logic clk = 0, rst_n = 0, fetch_enable = 0, branch = 0, ready = 0;
  logic resp_valid = 0, resp_err = 0;
  logic [31:0] branch_addr = 0, resp_rdata = 0;
  logic [CNT_W-1:0] fifo_cnt = 0, cnt_next = 0;
  logic trans_valid, fifo_push, fifo_flush, busy;
  logic [31:0] trans_addr, fifo_wdata;
  int total = 0, bad = 0, cyc = 0, lat = 1;
  bit pop_all = 0, pop_req = 0;
  logic [31:0] err_addr = 32'hFFFF_FFF0, exp_next = 0;
  logic [31:0] exp_q[$], grants[$], pushes[$], mem_addr[$];
  int mem_due[$];

  cv32e40p_fetch_fifo_filler #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fetch_enable), .branch_i(branch),
    .branch_addr_i(branch_addr), .trans_valid_o(trans_valid), .trans_ready_i(ready),
    .trans_addr_o(trans_addr), .resp_valid_i(resp_valid), .resp_rdata_i(resp_rdata),
    .resp_err_i(resp_err), .fifo_cnt_i(fifo_cnt), .fifo_push_o(fifo_push),
    .fifo_wdata_o(fifo_wdata), .fifo_flush_o(fifo_flush), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Live fetches follow the bench's own address sequence, restarted at each branch target.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst_n) begin
      total++;
      if (fifo_flush !== branch) begin bad++; $display("FAIL flush_eq_branch got=%b want=%b", fifo_flush, branch); end
      if (branch) begin exp_q.delete(); exp_next = branch_addr & ~32'h3; end
      if (fifo_push) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL unexpected_push got=%h want=none", fifo_wdata); end
        else begin
          e = exp_q.pop_front();
          if (fifo_wdata !== e) begin bad++; $display("FAIL push_data got=%h want=%h", fifo_wdata, e); end
        end
        pushes.push_back(fifo_wdata);
      end
      if (trans_valid && ready) begin
        grants.push_back(trans_addr);
        mem_addr.push_back(trans_addr);
        mem_due.push_back(cyc + lat);
        if (trans_addr == exp_next) begin exp_q.push_back(rd(trans_addr)); exp_next += 32'd4; end
      end
      cnt_next = (branch || pop_all) ? '0 :
                 CNT_W'(int'(fifo_cnt) + int'(fifo_push) - ((pop_req && fifo_cnt != 0) ? 1 : 0));
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    fifo_cnt = cnt_next;
    resp_valid = 0;
    resp_err = 0;
    resp_rdata = 0;
    if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
      resp_valid = 1;
      resp_rdata = rd(mem_addr[0]);
      resp_err = (mem_addr[0] == err_addr);
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
  end

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0; fetch_enable = 0; branch = 0; ready = 0; pop_all = 0; pop_req = 0; lat = 1;
    err_addr = 32'hFFFF_FFF0;
    repeat (2) @(posedge clk);
    mem_addr.delete(); mem_due.delete(); exp_q.delete(); grants.delete(); pushes.delete();
    exp_next = 0; cnt_next = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic drain(input string name);
    fetch_enable = 0; branch = 0; ready = 1; pop_req = 0;
    repeat (8) begin mid(); next(); end
    mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s_missing_push got=%0d want=0", name, exp_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy got=%b want=0", name, busy); end
    next();
  endtask

  task automatic test_reset();
    rst_n = 0; fetch_enable = 0; branch = 0; ready = 0;
    mid();
    total++; if (trans_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", trans_valid); end
    total++; if (trans_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", trans_addr); end
    total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b want=0", fifo_push); end
    total++; if (fifo_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", fifo_flush); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_fill();
    do_reset();
    fetch_enable = 1; ready = 1;
    mid();
    total++; if ({trans_valid, trans_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL fill_first got=%b/%h want=1/0", trans_valid, trans_addr); end
    next(); mid();
    total++; if ({resp_valid, trans_valid, busy} !== 3'b111) begin bad++; $display("FAIL resp_and_grant got=%b want=111", {resp_valid, trans_valid, busy}); end
    next(); mid();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_overlap got=%b want=1", busy); end
    next();
    repeat (2) begin mid(); next(); end
    mid();
    total++; if ({trans_valid, fifo_cnt} !== {1'b0, 2'd2}) begin bad++; $display("FAIL fill_throttle got=%b/%0d want=0/2", trans_valid, fifo_cnt); end
    total++; if (grants.size() != 2 || grants[0] !== 32'h0 || grants[1] !== 32'h4) begin bad++; $display("FAIL fill_grants got=%0d entries want=2 (0,4)", grants.size()); end
    next();
    pop_req = 1; mid(); next(); pop_req = 0;
    repeat (2) begin mid(); next(); end
    mid();
    total++; if (grants.size() != 3 || grants[2] !== 32'h8) begin bad++; $display("FAIL pop_refetch got=%0d entries want=3 (last 8)", grants.size()); end
    next();
    drain("fill");
  endtask

  task automatic test_branch();
    do_reset();
    lat = 3; pop_all = 1; fetch_enable = 1; ready = 1;
    mid(); next(); mid(); next();
    branch = 1; branch_addr = 32'h103;
    mid();
    total++; if ({fifo_flush, trans_valid, busy} !== 3'b101) begin bad++; $display("FAIL branch_cycle got=%b want=101", {fifo_flush, trans_valid, busy}); end
    total++; if (trans_addr !== 32'h100) begin bad++; $display("FAIL branch_target_addr got=%h want=100", trans_addr); end
    next();
    branch = 0;
    repeat (7) begin mid(); next(); end
    total++; if (grants.size() < 3 || grants[2] !== 32'h100) begin bad++; $display("FAIL branch_next_req got=%0d entries want>=3 (third 100)", grants.size()); end
    total++; if (pushes.size() == 0 || pushes[0] !== rd(32'h100)) begin bad++; $display("FAIL branch_first_push got=%0d pushes want first=%h", pushes.size(), rd(32'h100)); end
    drain("branch");
  endtask

  task automatic test_stall_branch();
    do_reset();
    pop_all = 1; fetch_enable = 1; ready = 0; branch = 1; branch_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      mid();
      total++; if ({trans_valid, trans_addr} !== {1'b1, 32'h20}) begin bad++; $display("FAIL stall_hold%0d got=%b/%h want=1/20", i, trans_valid, trans_addr); end
      next();
      branch_addr = 32'h300;
      branch = (i == 0);
      ready = (i == 2);
    end
    mid();
    total++; if ({trans_valid, trans_addr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL stall_target got=%b/%h want=1/300", trans_valid, trans_addr); end
    total++; if ({resp_valid, fifo_push} !== 2'b10) begin bad++; $display("FAIL stale_drop got=%b want=10", {resp_valid, fifo_push}); end
    next();
    drain("stall");
    total++; if (grants.size() < 2 || grants[0] !== 32'h20 || grants[1] !== 32'h300) begin bad++; $display("FAIL stall_grants got=%0d entries want 20,300", grants.size()); end
    total++; if (pushes.size() == 0 || pushes[0] !== rd(32'h300)) begin bad++; $display("FAIL stall_first_push got=%0d pushes want first=%h", pushes.size(), rd(32'h300)); end
  endtask

  task automatic test_wrap();
    do_reset();
    pop_all = 1; fetch_enable = 1; ready = 1; branch = 1; branch_addr = 32'hFFFF_FFFC;
    mid(); next();
    branch = 0;
    mid(); next();
    drain("wrap");
    total++; if (grants.size() < 2 || grants[0] !== 32'hFFFF_FFFC || grants[1] !== 32'h0) begin bad++; $display("FAIL wrap_grants got=%0d entries want fffffffc,0", grants.size()); end
  endtask

  task automatic test_err();
    do_reset();
    pop_all = 1; err_addr = 32'h8; fetch_enable = 1; ready = 1;
    repeat (8) begin mid(); next(); end
    mid();
`ifdef CV32E40P_FETCH_ERR_STOP_EN
    total++; if (grants.size() != 4 || grants[3] !== 32'hC || trans_valid !== 1'b0) begin bad++; $display("FAIL err_stop got=%0d grants valid=%b want=4 grants valid=0", grants.size(), trans_valid); end
`else
    total++; if (grants.size() < 8 || grants[7] !== 32'h1C) begin bad++; $display("FAIL err_ignored got=%0d grants want>=8 (eighth 1c)", grants.size()); end
`endif
    next();
    branch = 1; branch_addr = 32'h40;
    mid();
    total++; if ({trans_valid, trans_addr} !== {1'b1, 32'h40}) begin bad++; $display("FAIL err_resume got=%b/%h want=1/40", trans_valid, trans_addr); end
    next();
    branch = 0;
    mid(); next();
    drain("err");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
